// File: rtl/axis_group_sum.sv
// AXI-Stream group accumulator: sums runs of input beats (length cfg_len or s_last) into one result beat.
// Latency: result registered, visible on m_data 1 cycle after the closing beat is accepted.
// Backpressure: s_ready = !m_valid | m_ready; result held stable while m_valid & !m_ready.
// Optional: define AXIS_GROUP_SUM_SAT_EN to saturate m_data on overflow instead of wrapping.
module axis_group_sum #(
  parameter int W      = 16,
  parameter int MAX_N  = 8,
  parameter int SIGNED = 0,
  parameter int OW     = W + $clog2(MAX_N),
  localparam int AW    = W + $clog2(MAX_N),
  localparam int CW    = $clog2(MAX_N + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [CW-1:0] cfg_len,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [W-1:0]  s_data,
  input  logic          s_last,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [OW-1:0] m_data,
  output logic [CW-1:0] m_count,
  output logic          m_ovf
);

  // Group state: cnt_q==0 means the next accepted beat starts a new group
  logic [AW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] len_q, len_d;
  logic          m_valid_q, m_valid_d;
  logic [OW-1:0] m_data_q, m_data_d;
  logic [CW-1:0] m_count_q, m_count_d;
  logic          m_ovf_q, m_ovf_d;

  logic [AW-1:0] ext_data;
  logic [AW-1:0] sum;
  logic [CW-1:0] cfg_clamp;
  logic [CW-1:0] len_eff;
  logic [CW-1:0] beats;
  logic          first;
  logic          accept;
  logic          close;
  logic [OW-1:0] fit_data;
  logic          fit_ovf;

  assign s_ready = !m_valid_q || m_ready;
  assign accept  = s_valid && s_ready;

  // Datapath for the beat on the input: extension, running sum and close decision
  always_comb begin
    if (SIGNED != 0) ext_data = AW'($signed(s_data));
    else             ext_data = AW'(s_data);
    first     = (cnt_q == '0);
    cfg_clamp = (cfg_len == '0 || cfg_len > CW'(MAX_N)) ? CW'(MAX_N) : cfg_len;
    len_eff   = first ? cfg_clamp : len_q;
    beats     = cnt_q + CW'(1);
    sum       = first ? ext_data : acc_q + ext_data;
    close     = (beats == len_eff) || s_last;
  end

  generate
    if (OW == AW) begin : g_exact
      assign fit_data = sum;
      assign fit_ovf  = 1'b0;
    end else begin : g_narrow
`ifdef AXIS_GROUP_SUM_SAT_EN
      localparam logic [OW-1:0] SMIN = OW'(1) << (OW - 1);
      localparam logic [OW-1:0] SMAX = ~SMIN;
`endif
      // Range check of the exact sum against OW bits, then wrap or clamp
      always_comb begin
        if (SIGNED != 0) fit_ovf = !((&sum[AW-1:OW-1]) || !(|sum[AW-1:OW-1]));
        else             fit_ovf = |sum[AW-1:OW];
        fit_data = sum[OW-1:0];
`ifdef AXIS_GROUP_SUM_SAT_EN
        if (fit_ovf) begin
          if (SIGNED != 0) fit_data = sum[AW-1] ? SMIN : SMAX;
          else             fit_data = '1;
        end
`endif
      end
    end
  endgenerate

  // Next state: accumulate or close the group; output slot refills in the same cycle it drains
  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_count_d = m_count_q;
    m_ovf_d   = m_ovf_q;
    if (m_valid_q && m_ready) m_valid_d = 1'b0;
    if (accept) begin
      len_d = len_eff;
      if (close) begin
        acc_d     = '0;
        cnt_d     = '0;
        m_valid_d = 1'b1;
        m_data_d  = fit_data;
        m_count_d = beats;
        m_ovf_d   = fit_ovf;
      end else begin
        acc_d = sum;
        cnt_d = beats;
      end
    end
  end

  // State registers; reset drops any partial group and any pending result
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      len_q     <= CW'(MAX_N);
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_count_q <= '0;
      m_ovf_q   <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_count_q <= m_count_d;
      m_ovf_q   <= m_ovf_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_count = m_count_q;
  assign m_ovf   = m_ovf_q;

endmodule
